// File: rtl/ctrl_decode_pipe.sv
// Registered control decoder with a one-entry skid buffer, halt/illegal-instruction
// drain sequencing, flush and a retired-instruction counter.
module ctrl_decode_pipe #(
  parameter int REGSEL_W = 3,
  parameter int LINK_REG = 7,
  parameter bit PRIV_EN  = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [15:0]         in_instr,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_alu_src,
  output logic                out_reg_wr,
  output logic                out_mem_wr,
  output logic                out_mem_rd,
  output logic                out_mem_to_reg,
  output logic                out_inv_a,
  output logic                out_inv_b,
  output logic                out_cin,
  output logic [REGSEL_W-1:0] out_wr_reg,
  output logic                out_is_branch,
  output logic                out_is_jump,
  output logic                out_is_siic,
  output logic                out_is_rti,
  output logic                out_halt,
  output logic                out_err,
  output logic                halted,
  output logic [CNT_W-1:0]    retired,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  typedef struct packed {
    logic [2:0]          alu_src;
    logic                reg_wr;
    logic                mem_wr;
    logic                mem_rd;
    logic                mem_to_reg;
    logic                inv_a;
    logic                inv_b;
    logic                cin;
    logic [REGSEL_W-1:0] wr_reg;
    logic                is_branch;
    logic                is_jump;
    logic                is_siic;
    logic                is_rti;
    logic                halt;
    logic                err;
  } ctrl_t;

  logic [1:0]       state;
  logic             or_valid, sk_valid;
  ctrl_t            or_q, sk_q, dec;
  logic [CNT_W-1:0] retired_q;
  logic [4:0]       op;
  logic             acc, hs;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and once raised out_valid holds with stable data until taken.
  assign in_ready  = !sk_valid && (state != HALTED);
  assign out_valid = or_valid && (state != HALTED);
  assign acc       = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign op        = in_instr[15:11];

  always_comb begin
    dec         = '0;
    dec.alu_src = 3'd7;
    casez (op)
      5'b00000: dec.halt = 1'b1;
      5'b00010: begin
        if (PRIV_EN) dec.is_siic = 1'b1;
        else         dec.err     = 1'b1;
      end
      5'b00011: begin
        if (PRIV_EN) dec.is_rti = 1'b1;
        else         dec.err    = 1'b1;
      end
      5'b001??: begin
        dec.is_jump = 1'b1;
        if (op[1]) begin
          dec.reg_wr = 1'b1;
          dec.wr_reg = REGSEL_W'(LINK_REG);
        end
      end
      5'b010??: begin
        dec.alu_src = op[1] ? 3'd2 : 3'd1;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[7:5]);
        dec.inv_a   = (op[1:0] == 2'b01);
        dec.cin     = (op[1:0] == 2'b01);
        dec.inv_b   = (op[1:0] == 2'b11);
      end
      5'b011??: begin
        dec.is_branch = 1'b1;
        dec.alu_src   = 3'd5;
        dec.inv_b     = 1'b1;
        dec.cin       = 1'b1;
      end
      5'b10000: begin
        dec.alu_src = 3'd1;
        dec.mem_wr  = 1'b1;
      end
      5'b10001: begin
        dec.alu_src    = 3'd1;
        dec.mem_rd     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wr     = 1'b1;
        dec.wr_reg     = REGSEL_W'(in_instr[7:5]);
      end
      5'b10010: begin
        dec.alu_src = 3'd4;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[10:8]);
      end
      5'b10011: begin
        dec.alu_src = 3'd1;
        dec.mem_wr  = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[10:8]);
      end
      5'b101??: begin
        dec.alu_src = 3'd2;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[7:5]);
      end
      5'b11000: begin
        dec.alu_src = 3'd3;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[10:8]);
      end
      5'b11001, 5'b11010: begin
        dec.alu_src = 3'd0;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[4:2]);
      end
      5'b11011: begin
        dec.alu_src = 3'd0;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[4:2]);
        dec.inv_a   = (in_instr[1:0] == 2'b01);
        dec.cin     = (in_instr[1:0] == 2'b01);
        dec.inv_b   = (in_instr[1:0] == 2'b11);
      end
      5'b111??: begin
        dec.alu_src = 3'd0;
        dec.reg_wr  = 1'b1;
        dec.wr_reg  = REGSEL_W'(in_instr[4:2]);
        dec.inv_b   = (op[1:0] != 2'b11);
        dec.cin     = (op[1:0] != 2'b11);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      or_valid  <= 1'b0;
      sk_valid  <= 1'b0;
      or_q      <= '0;
      sk_q      <= '0;
      retired_q <= '0;
    end else if (flush && state != HALTED) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      state    <= RUN;
    end else begin
      // The first stop instruction to leave during DRAIN is the one that caused it.
      if (hs && state == DRAIN && (or_q.halt || or_q.err)) begin
        state    <= HALTED;
        or_valid <= 1'b0;
        sk_valid <= 1'b0;
      end else begin
        if (hs) begin
          if (sk_valid) begin
            or_q     <= sk_q;
            sk_valid <= 1'b0;
          end else if (acc) begin
            or_q <= dec;
          end else begin
            or_valid <= 1'b0;
          end
        end else if (acc) begin
          if (!or_valid) begin
            or_q     <= dec;
            or_valid <= 1'b1;
          end else begin
            sk_q     <= dec;
            sk_valid <= 1'b1;
          end
        end
        if (state == RUN && acc && (dec.halt || dec.err)) state <= DRAIN;
      end
      if (hs) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign out_alu_src    = or_q.alu_src;
  assign out_reg_wr     = or_q.reg_wr;
  assign out_mem_wr     = or_q.mem_wr;
  assign out_mem_rd     = or_q.mem_rd;
  assign out_mem_to_reg = or_q.mem_to_reg;
  assign out_inv_a      = or_q.inv_a;
  assign out_inv_b      = or_q.inv_b;
  assign out_cin        = or_q.cin;
  assign out_wr_reg     = or_q.wr_reg;
  assign out_is_branch  = or_q.is_branch;
  assign out_is_jump    = or_q.is_jump;
  assign out_is_siic    = or_q.is_siic;
  assign out_is_rti     = or_q.is_rti;
  assign out_halt       = or_q.halt;
  assign out_err        = or_q.err;
  assign halted         = (state == HALTED);
  assign retired        = retired_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios plus randomized traffic checked by a
// queue-based scoreboard against an opcode-table reference model.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic        in_ready, out_valid;
  logic [2:0]  out_alu_src;
  logic        out_reg_wr, out_mem_wr, out_mem_rd, out_mem_to_reg, out_inv_a, out_inv_b, out_cin;
  logic [2:0]  out_wr_reg;
  logic        out_is_branch, out_is_jump, out_is_siic, out_is_rti, out_halt, out_err;
  logic        halted;
  logic [3:0]  retired;
  logic [1:0]  state_dbg;

  logic        p_rst, p_flush, p_in_valid, p_out_ready;
  logic [15:0] p_in_instr;
  logic        p_in_ready, p_out_valid;
  logic [2:0]  p_out_alu_src;
  logic        p_reg_wr, p_mem_wr, p_mem_rd, p_mem_to_reg, p_inv_a, p_inv_b, p_cin;
  logic [2:0]  p_wr_reg;
  logic        p_is_branch, p_is_jump, p_is_siic, p_is_rti, p_halt, p_err;
  logic        p_halted;
  logic [15:0] p_retired;
  logic [1:0]  p_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [19:0] exp_q[$];
  bit          m_halted = 1'b0;
  int          m_retired = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.REGSEL_W(3), .LINK_REG(7), .PRIV_EN(1'b0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_src(out_alu_src), .out_reg_wr(out_reg_wr), .out_mem_wr(out_mem_wr),
    .out_mem_rd(out_mem_rd), .out_mem_to_reg(out_mem_to_reg), .out_inv_a(out_inv_a),
    .out_inv_b(out_inv_b), .out_cin(out_cin), .out_wr_reg(out_wr_reg),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump), .out_is_siic(out_is_siic),
    .out_is_rti(out_is_rti), .out_halt(out_halt), .out_err(out_err),
    .halted(halted), .retired(retired), .state_dbg(state_dbg)
  );

  ctrl_decode_pipe #(.PRIV_EN(1'b1)) dut_priv (
    .clk(clk), .rst(p_rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_instr(p_in_instr), .in_ready(p_in_ready),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_alu_src(p_out_alu_src), .out_reg_wr(p_reg_wr), .out_mem_wr(p_mem_wr),
    .out_mem_rd(p_mem_rd), .out_mem_to_reg(p_mem_to_reg), .out_inv_a(p_inv_a),
    .out_inv_b(p_inv_b), .out_cin(p_cin), .out_wr_reg(p_wr_reg),
    .out_is_branch(p_is_branch), .out_is_jump(p_is_jump), .out_is_siic(p_is_siic),
    .out_is_rti(p_is_rti), .out_halt(p_halt), .out_err(p_err),
    .halted(p_halted), .retired(p_retired), .state_dbg(p_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Layout {dont_care_alu, alu_src[2:0], reg_wr, mem_wr, mem_rd, mem_to_reg, inv_a, inv_b,
  // cin, wr_reg[2:0], is_branch, is_jump, is_siic, is_rti, halt, err}
  function automatic logic [19:0] model_decode(input logic [15:0] instr, input bit priv);
    int op, funct, alu;
    bit is_r, i1, dc, rw, mw, mr, ia, ib, ci, br, jp, si, rt, hl, er;
    logic [2:0] wr;
    op    = int'(instr[15:11]);
    funct = int'(instr[1:0]);
    is_r  = (op == 25) || (op == 26) || (op == 27) || (op >= 28);
    i1    = (op >= 8 && op <= 11) || (op >= 20 && op <= 23) || (op == 17);
    if (is_r)                                wr = instr[4:2];
    else if (i1)                             wr = instr[7:5];
    else if (op == 24 || op == 18 || op == 19) wr = instr[10:8];
    else if (op == 6 || op == 7)             wr = 3'd7;
    else                                     wr = 3'd0;
    rw = is_r || i1 || op == 19 || op == 24 || op == 18 || op == 6 || op == 7;
    mw = (op == 16) || (op == 19);
    mr = (op == 17);
    dc = 1'b0;
    if (op == 8 || op == 9 || op == 16 || op == 17 || op == 19) alu = 1;
    else if (op == 10 || op == 11 || (op >= 20 && op <= 23))    alu = 2;
    else if (op == 24)                                          alu = 3;
    else if (op == 18)                                          alu = 4;
    else if (op >= 12 && op <= 15)                              alu = 5;
    else if (is_r)                                              alu = 0;
    else begin alu = 7; dc = 1'b1; end
    ia = (op == 9) || (op == 27 && funct == 1);
    ib = (op == 11) || (op == 27 && funct == 3) || (op >= 28 && op <= 30) || (op >= 12 && op <= 15);
    ci = (op == 9) || (op == 27 && funct == 1) || (op >= 28 && op <= 30) || (op >= 12 && op <= 15);
    br = (op >= 12 && op <= 15);
    jp = (op >= 4 && op <= 7);
    hl = (op == 0);
    si = priv && (op == 2);
    rt = priv && (op == 3);
    er = !priv && (op == 2 || op == 3);
    return {dc, 3'(alu), rw, mw, mr, mr, ia, ib, ci, wr, br, jp, si, rt, hl, er};
  endfunction

  function automatic logic [18:0] dut_bundle();
    return {out_alu_src, out_reg_wr, out_mem_wr, out_mem_rd, out_mem_to_reg, out_inv_a,
            out_inv_b, out_cin, out_wr_reg, out_is_branch, out_is_jump, out_is_siic,
            out_is_rti, out_halt, out_err};
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [4:0] op;
    op = 5'($urandom_range(0, 31));
    if ((op == 5'd0 || op == 5'd2 || op == 5'd3) && $urandom_range(0, 5) != 0) op = 5'd1;
    return {op, 11'($urandom)};
  endfunction

  // Monitor/scoreboard: inputs change just after rising edges, so at the falling edge both
  // DUT outputs and next-edge inputs are settled; predict what the coming edge does.
  always @(negedge clk) begin
    logic [19:0] e;
    logic [19:0] mask;
    bit exp_rdy, exp_vld, stopping, halting;
    int exp_state;
    exp_rdy  = !m_halted && (exp_q.size() < 2);
    exp_vld  = !m_halted && (exp_q.size() > 0);
    stopping = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][1:0] != 2'b00) stopping = 1'b1;
    exp_state = m_halted ? 2 : (stopping ? 1 : 0);
    check("mon_in_ready", in_ready, exp_rdy);
    check("mon_out_valid", out_valid, exp_vld);
    check("mon_halted", halted, m_halted);
    check("mon_retired", retired, m_retired % 16);
    check("mon_state", state_dbg, exp_state);
    if (rst) begin
      exp_q.delete();
      m_halted  = 1'b0;
      m_retired = 0;
    end else if (flush && !m_halted) begin
      exp_q.delete();
    end else begin
      halting = 1'b0;
      if (exp_vld && out_ready) begin
        e    = exp_q.pop_front();
        mask = e[19] ? 20'h0FFFF : 20'h7FFFF;
        check("mon_bundle", {1'b0, dut_bundle()} & mask, e & mask);
        m_retired++;
        if (e[1:0] != 2'b00) begin
          halting  = 1'b1;
          m_halted = 1'b1;
          exp_q.delete();
        end
      end
      if (in_valid && exp_rdy && !halting) exp_q.push_back(model_decode(in_instr, 1'b0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ptick(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    p_rst = 1'b1; p_flush = 1'b0; p_in_valid = 1'b0; p_in_instr = '0; p_out_ready = 1'b0;
    ptick(2);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bundle", dut_bundle(), 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_state", state_dbg, 0);

    // ADDI then SUB under back-pressure
    in_valid = 1'b1; in_instr = 16'h4165;
    tick();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_bundle", dut_bundle(), {3'd1, 7'b1000000, 3'd3, 6'b0});
    in_valid = 1'b1; in_instr = 16'hD94D;
    tick();
    in_valid = 1'b0;
    check("bp_in_ready", in_ready, 0);
    check("bp_stable", dut_bundle(), {3'd1, 7'b1000000, 3'd3, 6'b0});
    out_ready = 1'b1;
    tick();
    check("sub_bundle", dut_bundle(), {3'd0, 7'b1000101, 3'd3, 6'b0});
    check("sub_valid", out_valid, 1);
    tick();
    check("bp_retired", retired, 2);
    check("bp_drained", out_valid, 0);

    // JAL
    in_valid = 1'b1; in_instr = 16'h3000;
    tick();
    in_valid = 1'b0;
    check("jal_wr_reg", out_wr_reg, 7);
    check("jal_reg_wr", out_reg_wr, 1);
    check("jal_is_jump", out_is_jump, 1);
    tick();

    // flush while draining a halt
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0000;
    tick();
    in_valid = 1'b0;
    check("drain_state", state_dbg, 1);
    check("drain_halt", out_halt, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_state", state_dbg, 0);
    check("flush_halted", halted, 0);
    check("flush_retired", retired, 3);

    // halt followed by a younger instruction
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 16'h0000;
    tick();
    check("halt_presented", out_halt & out_valid, 1);
    in_instr = 16'h4165;
    tick();
    check("halt_halted", halted, 1);
    check("halt_out_valid", out_valid, 0);
    check("halt_retired", retired, 4);
    ptick(3);
    in_valid = 1'b0;
    check("halt_in_ready", in_ready, 0);
    check("halt_retired_hold", retired, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_halted", halted, 0);
    check("post_rst_retired", retired, 0);

    // illegal privileged opcode without privilege support
    in_valid = 1'b1; in_instr = 16'h1000;
    tick();
    in_valid = 1'b0;
    check("err_flag", out_err, 1);
    check("err_reg_wr", out_reg_wr, 0);
    tick();
    check("err_halted", halted, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // privileged decode
    p_rst = 1'b0; p_out_ready = 1'b1;
    p_in_valid = 1'b1; p_in_instr = 16'h1000;
    tick();
    p_in_instr = 16'h1800;
    check("priv_siic", p_is_siic, 1);
    check("priv_siic_err", p_err, 0);
    tick();
    p_in_valid = 1'b0;
    check("priv_rti", p_is_rti, 1);
    tick();
    check("priv_halted", p_halted, 0);
    check("priv_in_ready", p_in_ready, 1);
    check("priv_retired", p_retired, 2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit burst;
      burst     = (i / 250) % 2 == 1;
      rst       = ($urandom_range(0, 199) == 0) || halted;
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = gen_instr();
      out_ready = burst ? 1'b1 : ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ptick(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
